// File: rtl/register_file_mp.sv
// Multi-read-port register file: one write then NUM_READ reads per request, served in pairs
// over a dual-port storage array. Define REGFILE_PARITY_EN for per-word even parity checking.
module register_file_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 4,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                           iClkX2,
   input  logic                           iRst_n,
   input  logic                           iReqValid,
   output logic                           oReady,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] iAddrRd,
   input  logic [NUM_READ-1:0]            iEnRd,
   input  logic [ADDR_WIDTH-1:0]          iAddrWr,
   input  logic [DATA_WIDTH-1:0]          iDataWr,
   input  logic                           iEnWr,
`ifdef REGFILE_PARITY_EN
   input  logic                           iParityInj,
   output logic [NUM_READ-1:0]            oParityErr,
`endif
   output logic [NUM_READ*DATA_WIDTH-1:0] oDataRd,
   output logic                           oRdValid
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;
   localparam int unsigned NPair = NUM_READ / 2;
   localparam int unsigned PairW = (NPair > 1) ? $clog2(NPair) : 1;
`ifdef REGFILE_PARITY_EN
   localparam int unsigned StoreW = DATA_WIDTH + 1;
`else
   localparam int unsigned StoreW = DATA_WIDTH;
`endif

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

   state_e                          state_q, state_d;
   logic [PairW-1:0]                pair_q, pair_d;
   logic [ADDR_WIDTH-1:0]           raddr_q [NUM_READ];
   logic [ADDR_WIDTH-1:0]           raddr_d [NUM_READ];
   logic [NUM_READ-1:0]             en_rd_q, en_rd_d;
   logic [ADDR_WIDTH-1:0]           waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
   logic                            en_wr_q, en_wr_d;
   logic [DATA_WIDTH-1:0]           cap_q [NUM_READ];
   logic [DATA_WIDTH-1:0]           cap_d [NUM_READ];
   logic [NUM_READ*DATA_WIDTH-1:0]  data_rd_q, data_rd_d;
   logic                            rd_valid_q, rd_valid_d;
   logic [StoreW-1:0]               mem_q [Depth];

   logic [ADDR_WIDTH-1:0]           rd_addr_a, rd_addr_b;
   logic [StoreW-1:0]               rd_word_a, rd_word_b;
   logic                            zero_a, zero_b;
   logic                            wr_en;
   logic [StoreW-1:0]               wr_word;
`ifdef REGFILE_PARITY_EN
   logic                            inj_q, inj_d;
   logic [NUM_READ-1:0]             cap_par_q, cap_par_d;
   logic [NUM_READ-1:0]             perr_q, perr_d;
`endif

   // Storage port A serves even read ports, port B odd ones, one pair per RD cycle.
   always_comb begin
      rd_addr_a = '0;
      rd_addr_b = '0;
      for (int p = 0; p < int'(NPair); p++) begin
         if (pair_q == PairW'(p)) begin
            rd_addr_a = raddr_q[2*p];
            rd_addr_b = raddr_q[2*p+1];
         end
      end
   end

   assign rd_word_a = mem_q[rd_addr_a];
   assign rd_word_b = mem_q[rd_addr_b];
   assign zero_a    = (ZERO_REG != 0) && (rd_addr_a == '0);
   assign zero_b    = (ZERO_REG != 0) && (rd_addr_b == '0);

   // Gated by reset so an aborted request can never land its write.
   assign wr_en = iRst_n && (state_q == StWrite) && en_wr_q &&
                  !((ZERO_REG != 0) && (waddr_q == '0));
`ifdef REGFILE_PARITY_EN
   assign wr_word = {(^wdata_q) ^ inj_q, wdata_q};
`else
   assign wr_word = wdata_q;
`endif

   always_ff @(posedge iClkX2) begin
      if (wr_en) begin
         mem_q[waddr_q] <= wr_word;
      end
   end

   always_comb begin
      state_d    = state_q;
      pair_d     = pair_q;
      raddr_d    = raddr_q;
      en_rd_d    = en_rd_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      en_wr_d    = en_wr_q;
      cap_d      = cap_q;
      data_rd_d  = data_rd_q;
      rd_valid_d = 1'b0;
`ifdef REGFILE_PARITY_EN
      inj_d      = inj_q;
      cap_par_d  = cap_par_q;
      perr_d     = perr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (iReqValid) begin
               for (int k = 0; k < int'(NUM_READ); k++) begin
                  raddr_d[k] = iAddrRd[k*ADDR_WIDTH +: ADDR_WIDTH];
               end
               en_rd_d = iEnRd;
               waddr_d = iAddrWr;
               wdata_d = iDataWr;
               en_wr_d = iEnWr;
`ifdef REGFILE_PARITY_EN
               inj_d   = iParityInj;
`endif
               state_d = StWrite;
            end
         end
         StWrite: begin
            pair_d  = '0;
            state_d = StRead;
         end
         StRead: begin
            for (int p = 0; p < int'(NPair); p++) begin
               if (pair_q == PairW'(p)) begin
                  cap_d[2*p]   = zero_a ? '0 : rd_word_a[DATA_WIDTH-1:0];
                  cap_d[2*p+1] = zero_b ? '0 : rd_word_b[DATA_WIDTH-1:0];
`ifdef REGFILE_PARITY_EN
                  cap_par_d[2*p]   = zero_a ? 1'b0 : rd_word_a[DATA_WIDTH];
                  cap_par_d[2*p+1] = zero_b ? 1'b0 : rd_word_b[DATA_WIDTH];
`endif
               end
            end
            if (pair_q == PairW'(NPair - 1)) begin
               state_d = StDone;
            end else begin
               pair_d = pair_q + PairW'(1);
            end
         end
         StDone: begin
            for (int k = 0; k < int'(NUM_READ); k++) begin
               if (en_rd_q[k]) begin
                  data_rd_d[k*DATA_WIDTH +: DATA_WIDTH] = cap_q[k];
`ifdef REGFILE_PARITY_EN
                  if (^{cap_par_q[k], cap_q[k]}) begin
                     perr_d[k] = 1'b1;
                  end
`endif
               end
            end
            rd_valid_d = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iClkX2) begin
      if (!iRst_n) begin
         state_q    <= StIdle;
         pair_q     <= '0;
         data_rd_q  <= '0;
         rd_valid_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
         perr_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pair_q     <= pair_d;
         data_rd_q  <= data_rd_d;
         rd_valid_q <= rd_valid_d;
`ifdef REGFILE_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   always_ff @(posedge iClkX2) begin
      raddr_q <= raddr_d;
      en_rd_q <= en_rd_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      en_wr_q <= en_wr_d;
      cap_q   <= cap_d;
`ifdef REGFILE_PARITY_EN
      inj_q     <= inj_d;
      cap_par_q <= cap_par_d;
`endif
   end

   assign oReady   = (state_q == StIdle);
   assign oRdValid = rd_valid_q;
   assign oDataRd  = data_rd_q;
`ifdef REGFILE_PARITY_EN
   assign oParityErr = perr_q;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus and are
// compared against an array model of the register contents and visible read results.
module tb_register_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req = 1'b0;
   logic [NR*AW-1:0] addr_rd = '0;
   logic [NR-1:0]    en_rd = '0;
   logic [AW-1:0]    addr_wr = '0;
   logic [DW-1:0]    data_wr = '0;
   logic             en_wr = 1'b0;
   logic             rdy1, rdy0, vld1, vld0;
   logic [NR*DW-1:0] dout1, dout0;
`ifdef REGFILE_PARITY_EN
   logic             inj = 1'b0;
   logic [NR-1:0]    perr1, perr0;
`endif

   always #5 clk = ~clk;

   register_file_mp #(.ZERO_REG(1)) u_dut1 (
      .iClkX2    (clk),
      .iRst_n    (rst_n),
      .iReqValid (req),
      .oReady    (rdy1),
      .iAddrRd   (addr_rd),
      .iEnRd     (en_rd),
      .iAddrWr   (addr_wr),
      .iDataWr   (data_wr),
      .iEnWr     (en_wr),
`ifdef REGFILE_PARITY_EN
      .iParityInj(inj),
      .oParityErr(perr1),
`endif
      .oDataRd   (dout1),
      .oRdValid  (vld1)
   );

   register_file_mp #(.ZERO_REG(0)) u_dut0 (
      .iClkX2    (clk),
      .iRst_n    (rst_n),
      .iReqValid (req),
      .oReady    (rdy0),
      .iAddrRd   (addr_rd),
      .iEnRd     (en_rd),
      .iAddrWr   (addr_wr),
      .iDataWr   (data_wr),
      .iEnWr     (en_wr),
`ifdef REGFILE_PARITY_EN
      .iParityInj(inj),
      .oParityErr(perr0),
`endif
      .oDataRd   (dout0),
      .oRdValid  (vld0)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: register contents, injected-bad flags and visible per-port results.
   logic [DW-1:0] m1 [32];
   logic [DW-1:0] m0 [32];
   bit            bad1 [32];
   bit            bad0 [32];
   logic [DW-1:0] e1 [NR];
   logic [DW-1:0] e0 [NR];
   logic [NR-1:0] p1 = '0;
   logic [NR-1:0] p0 = '0;

   logic [DW-1:0] o1 [NR];
   logic [DW-1:0] o0 [NR];
   int ready_acc, ready_low, ready_back, valid_at, cnt1, cnt0;

   function automatic logic [NR*AW-1:0] pack4(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                              input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic model_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic ew,
                              input logic pinj);
      if (ew) begin
         m0[wa] = wd;
         bad0[wa] = pinj;
         if (wa != 0) begin
            m1[wa] = wd;
            bad1[wa] = pinj;
         end
      end
   endtask

   task automatic model_read(input logic [NR*AW-1:0] ra, input logic [NR-1:0] en);
      logic [AW-1:0] a;
      for (int k = 0; k < NR; k++) begin
         if (en[k]) begin
            a = ra[k*AW +: AW];
            e0[k] = m0[a];
            if (bad0[a]) p0[k] = 1'b1;
            if (a == 0) begin
               e1[k] = '0;
            end else begin
               e1[k] = m1[a];
               if (bad1[a]) p1[k] = 1'b1;
            end
         end
      end
   endtask

   // Issues one request from a negedge, scrambles inputs after acceptance and records timing
   // and the data seen in the valid cycle. Returns at a negedge with both DUTs idle.
   task automatic run_req(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic ew,
                          input logic [NR*AW-1:0] ra, input logic [NR-1:0] en,
                          input logic pinj);
      ready_acc = (rdy1 && rdy0) ? 1 : 0;
      addr_wr = wa;
      data_wr = wd;
      en_wr   = ew;
      addr_rd = ra;
      en_rd   = en;
      req     = 1'b1;
`ifdef REGFILE_PARITY_EN
      inj     = pinj;
`endif
      @(posedge clk);
      model_write(wa, wd, ew, pinj);
      model_read(ra, en);
      @(negedge clk);
      req     = 1'b0;
      addr_wr = AW'($urandom);
      data_wr = $urandom;
      en_wr   = 1'($urandom);
      addr_rd = (NR*AW)'($urandom);
      en_rd   = NR'($urandom);
`ifdef REGFILE_PARITY_EN
      inj     = 1'($urandom);
`endif
      ready_low = 0; ready_back = 0; valid_at = -1; cnt1 = 0; cnt0 = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c <= 4 && !rdy1 && !rdy0) ready_low++;
         if (c == 5 && rdy1 && rdy0) ready_back = 1;
         if (vld1) begin
            cnt1++;
            if (valid_at < 0) valid_at = c;
         end
         if (vld0) cnt0++;
         if (c == 5) begin
            for (int k = 0; k < NR; k++) begin
               o1[k] = dout1[k*DW +: DW];
               o0[k] = dout0[k*DW +: DW];
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
         n_err++; $display("FAIL reset ready: got %b/%b want 1/1", rdy1, rdy0);
      end
      n_vec++;
      if (vld1 !== 1'b0 || vld0 !== 1'b0) begin
         n_err++; $display("FAIL reset valid: got %b/%b want 0/0", vld1, vld0);
      end
      n_vec++;
      if (dout1 !== '0 || dout0 !== '0) begin
         n_err++; $display("FAIL reset data: got %h / %h want 0", dout1, dout0);
      end
      n_vec++;
      for (int k = 0; k < NR; k++) begin
         e1[k] = '0;
         e0[k] = '0;
      end
      p1 = '0;
      p0 = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic init_regs;
      for (int a = 0; a < 32; a++) begin
         run_req(AW'(a), $urandom, 1'b1, '0, '0, 1'b0);
      end
   endtask

   task automatic test_basic;
      run_req(5'd5, 32'hDEADBEEF, 1'b1, '0, 4'b0000, 1'b0);
      if (valid_at != 5 || cnt1 != 1 || cnt0 != 1) begin
         n_err++; $display("FAIL basic wr valid: got at=%0d n=%0d/%0d want at=5 n=1/1",
                           valid_at, cnt1, cnt0);
      end
      n_vec++;
      run_req(5'd9, $urandom, 1'b0, pack4(5, 5, 5, 5), 4'b1111, 1'b0);
      if (ready_acc != 1 || ready_low != 4 || ready_back != 1) begin
         n_err++; $display("FAIL basic ready: got acc=%0d low=%0d back=%0d want 1 4 1",
                           ready_acc, ready_low, ready_back);
      end
      n_vec++;
      if (valid_at != 5 || cnt1 != 1 || cnt0 != 1) begin
         n_err++; $display("FAIL basic rd valid: got at=%0d n=%0d/%0d want at=5 n=1/1",
                           valid_at, cnt1, cnt0);
      end
      n_vec++;
      for (int k = 0; k < NR; k++) begin
         if (o1[k] !== 32'hDEADBEEF || o0[k] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic port%0d: got %h/%h want deadbeef", k, o1[k], o0[k]);
         end
         n_vec++;
      end
   endtask

   task automatic test_write_first;
      run_req(5'd7, 32'hA5A5A5A5, 1'b1, '0, 4'b0000, 1'b0);
      run_req(5'd3, 32'h12345678, 1'b1, pack4(3, 7, AW'($urandom), AW'($urandom)), 4'b1111,
              1'b0);
      if (o1[0] !== 32'h12345678 || o0[0] !== 32'h12345678) begin
         n_err++; $display("FAIL wfirst port0: got %h/%h want 12345678", o1[0], o0[0]);
      end
      n_vec++;
      if (o1[1] !== 32'hA5A5A5A5 || o0[1] !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL wfirst port1: got %h/%h want a5a5a5a5", o1[1], o0[1]);
      end
      n_vec++;
      for (int k = 2; k < NR; k++) begin
         if (o1[k] !== e1[k] || o0[k] !== e0[k]) begin
            n_err++; $display("FAIL wfirst port%0d: got %h/%h want %h/%h", k, o1[k], o0[k],
                              e1[k], e0[k]);
         end
         n_vec++;
      end
   endtask

   task automatic test_zero_reg;
      run_req(5'd0, 32'hFFFFFFFF, 1'b1, '0, 4'b0000, 1'b0);
      run_req(5'd1, $urandom, 1'b0, pack4(0, 0, 0, 0), 4'b1111, 1'b0);
      for (int k = 0; k < NR; k++) begin
         if (o1[k] !== 32'h0) begin
            n_err++; $display("FAIL zero z1 port%0d: got %h want 00000000", k, o1[k]);
         end
         n_vec++;
         if (o0[k] !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL zero z0 port%0d: got %h want ffffffff", k, o0[k]);
         end
         n_vec++;
      end
   endtask

   task automatic test_partial_enable;
      logic [DW-1:0] wd;
      run_req(5'd10, 32'h11111111, 1'b1, pack4(10, 10, 10, 10), 4'b1111, 1'b0);
      for (int k = 0; k < NR; k++) begin
         if (o1[k] !== 32'h11111111 || o0[k] !== 32'h11111111) begin
            n_err++; $display("FAIL pen setup port%0d: got %h/%h want 11111111", k, o1[k], o0[k]);
         end
         n_vec++;
      end
      wd = $urandom;
      run_req(5'd12, wd, 1'b1, pack4(12, 12, 12, 12), 4'b0101, 1'b0);
      for (int k = 0; k < NR; k++) begin
         if (k % 2 == 1) begin
            if (o1[k] !== 32'h11111111 || o0[k] !== 32'h11111111) begin
               n_err++; $display("FAIL pen hold port%0d: got %h/%h want 11111111", k, o1[k],
                                 o0[k]);
            end
         end else begin
            if (o1[k] !== wd || o0[k] !== wd) begin
               n_err++; $display("FAIL pen new port%0d: got %h/%h want %h", k, o1[k], o0[k], wd);
            end
         end
         n_vec++;
      end
   endtask

   task automatic test_reset_abort;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            stray;
      wa = AW'($urandom_range(1, 31));
      wd = $urandom;
      addr_wr = wa; data_wr = wd; en_wr = 1'b1;
      addr_rd = pack4(wa, wa, wa, wa); en_rd = 4'b1111; req = 1'b1;
      @(posedge clk);
      model_write(wa, wd, 1'b1, 1'b0);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      if (rdy1 !== 1'b1 || rdy0 !== 1'b1 || vld1 !== 1'b0 || vld0 !== 1'b0) begin
         n_err++; $display("FAIL abort ctl: got rdy=%b/%b vld=%b/%b want 1/1 0/0",
                           rdy1, rdy0, vld1, vld0);
      end
      n_vec++;
      if (dout1 !== '0 || dout0 !== '0) begin
         n_err++; $display("FAIL abort data: got %h / %h want 0", dout1, dout0);
      end
      n_vec++;
      for (int k = 0; k < NR; k++) begin
         e1[k] = '0;
         e0[k] = '0;
      end
      p1 = '0;
      p0 = '0;
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         if (vld1 || vld0) stray++;
         @(negedge clk);
      end
      if (stray != 0) begin
         n_err++; $display("FAIL abort stray valid: got %0d pulses want 0", stray);
      end
      n_vec++;
      run_req(AW'($urandom_range(1, 31)), $urandom, 1'b1, pack4(wa, 0, wa, 7), 4'b1011, 1'b0);
      if (valid_at != 5 || cnt1 != 1 || cnt0 != 1) begin
         n_err++; $display("FAIL abort next valid: got at=%0d n=%0d/%0d want at=5 n=1/1",
                           valid_at, cnt1, cnt0);
      end
      n_vec++;
      for (int k = 0; k < NR; k++) begin
         if (o1[k] !== e1[k] || o0[k] !== e0[k]) begin
            n_err++; $display("FAIL abort next port%0d: got %h/%h want %h/%h", k, o1[k], o0[k],
                              e1[k], e0[k]);
         end
         n_vec++;
      end
   endtask

   task automatic test_random;
      logic [NR*AW-1:0] ra;
      logic [AW-1:0]    same;
      for (int i = 0; i < 40; i++) begin
         ra = (NR*AW)'({$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) begin
            same = AW'($urandom_range(0, 3));
            ra = pack4(same, same, same, same);
         end
         run_req(AW'($urandom), $urandom, 1'($urandom), ra, NR'($urandom), 1'b0);
         if (ready_acc != 1 || ready_low != 4 || ready_back != 1 || valid_at != 5 ||
             cnt1 != 1 || cnt0 != 1) begin
            n_err++; $display("FAIL rand%0d timing: got acc=%0d low=%0d back=%0d at=%0d n=%0d/%0d",
                              i, ready_acc, ready_low, ready_back, valid_at, cnt1, cnt0);
         end
         n_vec++;
         for (int k = 0; k < NR; k++) begin
            if (o1[k] !== e1[k] || o0[k] !== e0[k]) begin
               n_err++; $display("FAIL rand%0d port%0d: got %h/%h want %h/%h", i, k, o1[k],
                                 o0[k], e1[k], e0[k]);
            end
            n_vec++;
         end
      end
   endtask

`ifdef REGFILE_PARITY_EN
   task automatic test_parity;
      run_req(5'd9, $urandom, 1'b1, pack4(1, 2, 9, 4), 4'b0100, 1'b1);
      if (perr1 !== 4'b0100 || perr0 !== 4'b0100 || perr1 !== p1 || perr0 !== p0) begin
         n_err++; $display("FAIL parity flag: got %b/%b want 0100", perr1, perr0);
      end
      n_vec++;
      for (int i = 0; i < 3; i++) begin
         run_req(AW'($urandom_range(10, 31)), $urandom, 1'b1,
                 pack4(AW'($urandom_range(10, 31)), 0, AW'($urandom_range(10, 31)), 3),
                 4'b1111, 1'b0);
         if (perr1 !== 4'b0100 || perr0 !== 4'b0100) begin
            n_err++; $display("FAIL parity sticky%0d: got %b/%b want 0100", i, perr1, perr0);
         end
         n_vec++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      p1 = '0;
      p0 = '0;
      if (perr1 !== 4'b0000 || perr0 !== 4'b0000) begin
         n_err++; $display("FAIL parity clear: got %b/%b want 0000", perr1, perr0);
      end
      n_vec++;
      @(negedge clk);
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset;
      init_regs;
      test_basic;
      test_write_first;
      test_zero_reg;
      test_partial_enable;
      test_reset_abort;
      test_random;
`ifdef REGFILE_PARITY_EN
      test_parity;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
